// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI-lite user-port arbiter: FSM encoding and response codes.
package axil_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrWait = 2'd1,
        StRdWait = 2'd2
    } arb_state_e;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, wrapping around.
module axil_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    int unsigned w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        // Offset 1..NUM_REQ visits i_last+1 first and i_last itself last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_pos = (int'(i_last) + off) % NUM_REQ;
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = IW'(w_pos);
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_user_arbiter.sv
// Round-robin arbiter sharing one AXI-lite user port among NUM_REQ requesters,
// one transaction in flight, with a per-transaction ready timeout.
module axil_user_arbiter
    import axil_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic                      o_rsp_err,
    output logic [DATA_W-1:0]         o_rsp_rdata,
    output logic                      o_write,
    output logic                      o_read,
    output logic [ADDR_W-1:0]         o_user_waddr,
    output logic [DATA_W-1:0]         o_user_wdata,
    output logic [ADDR_W-1:0]         o_user_raddr,
    input  logic [DATA_W-1:0]         i_user_rdata,
    input  logic                      i_wr_ready,
    input  logic                      i_rd_ready,
    output logic                      o_busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    arb_state_e          r_state;
    logic [IW-1:0]       r_owner;
    logic [NUM_REQ-1:0]  r_owner_oh;
    logic [IW-1:0]       r_last;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_write;
    logic                r_read;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_raddr;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    axil_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req   (i_req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_addr  = i_req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = i_req_wdata[w_idx*DATA_W +: DATA_W];
    assign w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_owner     <= '0;
            r_owner_oh  <= '0;
            r_last      <= IW'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_req_ack   <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= RSP_OK;
            r_rsp_rdata <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_busy      <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_raddr     <= '0;
        end else begin
            r_req_ack   <= '0;
            r_rsp_valid <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_owner    <= w_idx;
                        r_owner_oh <= w_grant;
                        r_req_ack  <= w_grant;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        if (i_req_we[w_idx]) begin
                            r_write <= 1'b1;
                            r_waddr <= w_sel_addr;
                            r_wdata <= w_sel_wdata;
                            r_state <= StWrWait;
                        end else begin
                            r_read  <= 1'b1;
                            r_raddr <= w_sel_addr;
                            r_state <= StRdWait;
                        end
                    end
                end
                StWrWait: begin
                    // Ready beats the timeout when both land in the same cycle.
                    if (i_wr_ready || w_timeout) begin
                        r_write     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= r_owner_oh;
                        r_rsp_err   <= i_wr_ready ? RSP_OK : RSP_TIMEOUT;
                        r_last      <= r_owner;
                        r_state     <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRdWait: begin
                    if (i_rd_ready || w_timeout) begin
                        r_read      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= r_owner_oh;
                        r_rsp_err   <= i_rd_ready ? RSP_OK : RSP_TIMEOUT;
                        r_rsp_rdata <= i_rd_ready ? i_user_rdata : '0;
                        r_last      <= r_owner;
                        r_state     <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_req_ack    = r_req_ack;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_err    = r_rsp_err;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_write      = r_write;
    assign o_read       = r_read;
    assign o_busy       = r_busy;
    assign o_user_waddr = r_waddr;
    assign o_user_wdata = r_wdata;
    assign o_user_raddr = r_raddr;

endmodule

// File: tb/tb_axil_user_arbiter.sv
// Directed bench for axil_user_arbiter: vector table of single transactions plus
// hand sequences for stray readies, reset mid-read and back-to-back round-robin.
module tb_axil_user_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            write;
    logic            read;
    logic [AW-1:0]   user_waddr;
    logic [DW-1:0]   user_wdata;
    logic [AW-1:0]   user_raddr;
    logic [DW-1:0]   user_rdata;
    logic            wr_ready;
    logic            rd_ready;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axil_user_arbiter #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_req_ack    (req_ack),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_err    (rsp_err),
        .o_rsp_rdata  (rsp_rdata),
        .o_write      (write),
        .o_read       (read),
        .o_user_waddr (user_waddr),
        .o_user_wdata (user_wdata),
        .o_user_raddr (user_raddr),
        .i_user_rdata (user_rdata),
        .i_wr_ready   (wr_ready),
        .i_rd_ready   (rd_ready),
        .o_busy       (busy)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy_at;     // strobe cycle (1-based) carrying ready; 0 = never
        logic [31:0] rdata;
        int          exp_owner;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_hi;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] v, input logic [3:0] we,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = a + (i << 8);
            req_wdata[i*DW +: DW] = d ^ i;
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic [3:0]  oh;
        logic [31:0] eaddr;
        bit          got;
        bit          done;
        int          hi;
        oh    = 4'b0001 << v.exp_owner;
        eaddr = v.addr + (v.exp_owner << 8);
        @(negedge clk);
        drive_req(v.valid, v.we, v.addr, v.wdata);
        got = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (req_ack != 0) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk($sformatf("v%0d_ack_timeout", k), 32'd0, 32'd1);
            req_valid = '0;
            return;
        end
        chk($sformatf("v%0d_ack", k), {28'd0, req_ack}, {28'd0, oh});
        chk($sformatf("v%0d_strobe", k), {30'd0, write, read},
            v.we[v.exp_owner] ? 32'd2 : 32'd1);
        // Scramble request fields: the arbiter must keep using its latched copy.
        req_valid = '0;
        req_addr  = {NR{32'hDEAD_DEAD}};
        req_wdata = {NR{32'hDEAD_DEAD}};
        hi   = 1;
        done = 0;
        for (int t = 0; t < 20; t++) begin
            wr_ready   = (v.rdy_at == hi) && v.we[v.exp_owner];
            rd_ready   = (v.rdy_at == hi) && !v.we[v.exp_owner];
            user_rdata = (v.rdy_at == hi) ? v.rdata : 32'hBAD0_BAD0;
            @(negedge clk);
            if (write || read) begin
                hi++;
            end else begin
                done = 1;
                break;
            end
        end
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        chk($sformatf("v%0d_done", k), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_hi_cycles", k), hi, v.exp_hi);
        chk($sformatf("v%0d_rsp_valid", k), {28'd0, rsp_valid}, {28'd0, oh});
        chk($sformatf("v%0d_rsp_err", k), {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_rsp_rdata", k), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd0);
        if (v.we[v.exp_owner]) begin
            chk($sformatf("v%0d_waddr", k), user_waddr, eaddr);
            chk($sformatf("v%0d_wdata", k), user_wdata, v.wdata ^ v.exp_owner);
        end else begin
            chk($sformatf("v%0d_raddr", k), user_raddr, eaddr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        int         rr[5];
        //          valid    we       addr          wdata         rdy rdata         own err exp_rdata     hi
        vecs[0] = '{4'b0001, 4'b0001, 32'h0000_0000, 32'h0000_1234, 3, 32'h0,        0, 0, 32'h0,        3};
        vecs[1] = '{4'b0100, 4'b0000, 32'h0000_0004, 32'h0,        1, 32'h0000_BEEF, 2, 0, 32'h0000_BEEF, 1};
        vecs[2] = '{4'b1000, 4'b1000, 32'h0000_0010, 32'hA5A5_0000, 0, 32'h0,        3, 1, 32'h0000_BEEF, 8};
        vecs[3] = '{4'b0010, 4'b0000, 32'h0000_0020, 32'h0,        0, 32'h1111_1111, 1, 1, 32'h0,        8};
        vecs[4] = '{4'b0001, 4'b0000, 32'h0000_0030, 32'h0,        8, 32'h0000_CAFE, 0, 0, 32'h0000_CAFE, 8};
        vecs[5] = '{4'b1111, 4'b0101, 32'h0000_0040, 32'h0,        2, 32'h0000_0055, 1, 0, 32'h0000_0055, 2};
        vecs[6] = '{4'b1001, 4'b1000, 32'h0000_0050, 32'h7777_0000, 1, 32'h0,        3, 0, 32'h0000_0055, 1};
        vecs[7] = '{4'b0011, 4'b0001, 32'h0000_0060, 32'h9999_0000, 2, 32'h0,        0, 0, 32'h0000_0055, 2};

        reset      = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        user_rdata = '0;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {req_ack, rsp_valid, 22'd0, rsp_err, write, read, busy}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;

        // Stray readies while idle must be ignored.
        @(negedge clk);
        wr_ready   = 1'b1;
        rd_ready   = 1'b1;
        user_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("stray_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("stray_strobe", {29'd0, write, read, busy}, 32'd0);
        chk("stray_rdata", rsp_rdata, 32'd0);
        wr_ready = 1'b0;
        rd_ready = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Reset in the middle of a read: strobe drops at once, no response follows.
        @(negedge clk);
        drive_req(4'b0001, 4'b0000, 32'h0000_0070, 32'h0);
        @(negedge clk);
        chk("rst_mid_read_started", {30'd0, write, read}, 32'd1);
        req_valid = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_mid_async_read", {30'd0, read, busy}, 32'd0);
        @(negedge clk);
        chk("rst_mid_no_rsp", {28'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_release", {req_ack, rsp_valid, 23'd0, write, read, busy}, 32'd0);

        // All requesters held with ready always high: 0,1,2,3,0 with one idle cycle between.
        rr = '{0, 1, 2, 3, 0};
        drive_req(4'b1111, 4'b0101, 32'h0000_0100, 32'h0000_4000);
        wr_ready   = 1'b1;
        rd_ready   = 1'b1;
        user_rdata = 32'h0000_0077;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << rr[k];
            @(negedge clk);
            chk($sformatf("rr%0d_ack", k), {28'd0, req_ack}, {28'd0, oh});
            chk($sformatf("rr%0d_strobe", k), {30'd0, write, read},
                (rr[k] % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 4) req_valid = '0;
            @(negedge clk);
            chk($sformatf("rr%0d_rsp", k), {28'd0, rsp_valid}, {28'd0, oh});
            chk($sformatf("rr%0d_gap", k), {30'd0, write, read}, 32'd0);
        end
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        chk("rr_idle_after", {28'd0, req_ack}, 32'd0);
        chk("rr_last_rdata", rsp_rdata, 32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
